// File: rtl/rr_arbiter4way16.sv
// Four-requester round-robin arbiter with bounded bursts driving a 16-bit word mux.
// One idle cycle separates grants; the last-served pointer sets next-grant priority.
module rr_arbiter4way16 #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic        out_ready,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        busy
);

  // state | meaning
  // IDLE  | no grant held; picks the next requester after ptr
  // SERVE | gnt/sel hold one requester until its burst ends or it drops req

  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_t;

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [1:0]    pick;
  logic [1:0]    idx;
  logic          pick_valid;

  // Walk the search order backwards so the nearest requester after ptr wins.
  always_comb begin
    pick       = ptr;
    pick_valid = 1'b0;
    idx        = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  assign busy      = (state == SERVE);
  assign out_valid = busy & req[sel];

  always_comb begin
    out = 16'h0000;
    if (out_valid) begin
      case (sel)
        2'd0:    out = a;
        2'd1:    out = b;
        2'd2:    out = c;
        default: out = d;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      ptr   <= 2'b11;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= SERVE;
            gnt   <= 4'b0001 << pick;
            sel   <= pick;
            cnt   <= '0;
          end
        end
        SERVE: begin
          if (!req[sel]) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            ptr   <= sel;
            cnt   <= '0;
          end else if (out_ready) begin
            if (cnt == LAST_BEAT) begin
              state <= IDLE;
              gnt   <= 4'b0000;
              ptr   <= sel;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter4way16.sv
// Directed bench for rr_arbiter4way16: a queue-free owner/last-served model is
// compared every cycle, with literal expectations pinning the key scenarios.
module tb_rr_arbiter4way16;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [15:0] a = 16'h1234, b = 16'h9876, c = 16'hAAAA, d = 16'h5555;
  logic        out_ready = 1'b1;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rr_arbiter4way16 #(.MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .out_ready(out_ready), .gnt(gnt), .sel(sel), .out(out),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input int i);
    case (i)
      0: return a;
      1: return b;
      2: return c;
      default: return d;
    endcase
  endfunction

  // Model: owner = requester being served (-1 when idle), last = last served.
  int owner = -1;
  int last  = 3;
  int beats = 0;
  int m_sel = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1; last = 3; beats = 0; m_sel = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (owner < 0 && req[(last + k) % 4]) begin
          owner = (last + k) % 4;
          m_sel = owner;
          beats = 0;
        end
      end
    end else if (!req[owner]) begin
      last = owner; owner = -1; beats = 0;
    end else if (out_ready) begin
      beats++;
      if (beats == MAXB) begin
        last = owner; owner = -1; beats = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic       e_busy;
      logic       e_valid;
      e_busy  = (owner >= 0);
      e_valid = e_busy && req[owner];
      chk("m_busy", busy, e_busy);
      chk("m_gnt", gnt, e_busy ? (4'b0001 << owner) : 4'b0000);
      chk("m_sel", sel, m_sel);
      chk("m_valid", out_valid, e_valid);
      chk("m_out", out, e_valid ? word_of(owner) : 16'h0000);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for a grant, then runs it to completion counting accepted beats.
  task automatic grant(input string name, input logic [3:0] eg, input logic [15:0] ew,
                       input int exp_beats, input int exp_idle);
    int n = 0, idle = 0, guard = 0, badw = 0;
    while (!busy && guard < 10) begin
      idle++; guard++; cyc(); #2;
    end
    chk({name, "_gnt"}, gnt, eg);
    if (exp_idle >= 0) chk({name, "_idle"}, idle, exp_idle);
    guard = 0;
    while (busy && guard < 40) begin
      if (out_valid && out !== ew) badw++;
      if (out_valid && out_ready) n++;
      guard++; cyc(); #2;
    end
    chk({name, "_beats"}, n, exp_beats);
    chk({name, "_word"}, badw, 0);
  endtask

  initial begin
    int guard;
    int held;
    #1 rst_n = 1'b0;
    req = 4'b1111;
    repeat (3) cyc();
    #2;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_out", out, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    req = 4'b0000;
    rst_n = 1'b1;
    cyc(); #2;
    cyc(); #2;
    chk("idle_noreq", gnt, 4'b0000);

    // Single requester c.
    req = 4'b0100;
    cyc(); #2;
    chk("single_gnt", gnt, 4'b0100);
    held = (out_valid && out == 16'hAAAA) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      cyc(); #2;
      if (out_valid && out == 16'hAAAA) held++;
    end
    chk("single_words", held, 4);
    cyc(); #2;
    chk("single_gap", gnt, 4'b0000);
    cyc(); #2;
    chk("single_regrant", gnt, 4'b0100);
    req = 4'b0000;
    cyc(); #2;
    cyc(); #2;

    // Round robin from a fresh pointer.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    req = 4'b1111;
    grant("rr0", 4'b0001, 16'h1234, 4, 1);
    grant("rr1", 4'b0010, 16'h9876, 4, 1);
    grant("rr2", 4'b0100, 16'hAAAA, 4, 1);
    grant("rr3", 4'b1000, 16'h5555, 4, 1);
    grant("rr4", 4'b0001, 16'h1234, 4, 1);

    // Backpressure on b.
    guard = 0;
    while (!busy && guard < 10) begin guard++; cyc(); #2; end
    chk("bp_gnt", gnt, 4'b0010);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin cyc(); #2; end
      chk("bp_out", out, 16'h9876);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_sel", sel, 2'b01);
    end
    cyc(); #2;
    out_ready = 1'b1;
    held = 0; guard = 0;
    while (busy && guard < 20) begin held++; guard++; cyc(); #2; end
    chk("bp_resume_beats", held, 4);

    // Early drop of a while d waits.
    req = 4'b0001;
    guard = 0;
    while (!busy && guard < 10) begin guard++; cyc(); #2; end
    chk("drop_gnt", gnt, 4'b0001);
    req = 4'b1001;
    cyc(); #2;
    chk("drop_hold", gnt, 4'b0001);
    cyc(); #1;
    req = 4'b1000;
    #1;
    chk("drop_valid", out_valid, 1'b0);
    chk("drop_out", out, 16'h0000);
    cyc(); #2;
    chk("drop_idle", busy, 1'b0);
    cyc(); #2;
    chk("drop_next", gnt, 4'b1000);

    // Reset in the middle of d's burst.
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 4'b0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_out", out, 16'h0000);
    req = 4'b1111;
    rst_n = 1'b1;
    cyc(); #2;
    chk("mid_rst_first", gnt, 4'b0001);
    req = 4'b0000;
    repeat (3) cyc();
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4way16.md
RR_ARBITER4WAY16 -- requirements
Module: rr_arbiter4way16

Interface
REQ-001 SHALL have parameter: MAX_BURST, default 4, maximum accepted beats per grant (range 1..15).
REQ-002 SHALL have one clock and an asynchronous, active-low reset.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: req  input  4  request per requester; bit 0 = a, bit 1 = b, bit 2 = c, bit 3 = d.
REQ-006 SHALL have ports: a, b, c, d  input  16 each  requester data words.
REQ-007 SHALL have port: out_ready  input  1  downstream accepts the current word.
REQ-008 SHALL have port: gnt  output  4  one-hot grant, registered.
REQ-009 SHALL have port: sel  output  2  registered select driving the 4-way 16-bit mux.
REQ-010 SHALL have port: out  output  16  selected data word.
REQ-011 SHALL have port: out_valid  output  1  out holds a valid word.
REQ-012 SHALL have port: busy  output  1  high in SERVE state.

Function
REQ-013 SHALL implement two states: IDLE and SERVE.
REQ-014 SHALL keep a 2-bit last-served pointer ptr; search order from IDLE: ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-015 SHALL, in IDLE with any req bit high at edge n, enter SERVE at edge n+1 with gnt one-hot, sel equal to the chosen index, and beat count 0.
REQ-016 SHALL stay in IDLE with gnt=0000 while req=0000.
REQ-017 SHALL drive out_valid = busy AND req[sel], combinationally.
REQ-018 SHALL drive out = the selected word (sel 0..3 -> a..d) when out_valid=1, and 16'h0000 otherwise.
REQ-019 SHALL count a beat only on a cycle where out_valid=1 and out_ready=1.
REQ-020 SHALL leave SERVE for IDLE at the edge where the beat count reaches MAX_BURST.
REQ-021 SHALL leave SERVE for IDLE at the edge where req[sel]=0 (no beat that cycle).
REQ-022 SHALL, on leaving SERVE, set ptr <= sel, clear gnt, and clear the beat count.
REQ-023 SHALL leave exactly one IDLE cycle between consecutive grants.
REQ-024 SHALL, under out_ready=0, hold sel, gnt and the beat count unchanged without timeout.
REQ-025 SHALL ignore changes on non-granted req bits during SERVE.
REQ-026 SHALL keep the beat counter wide enough for MAX_BURST; it SHALL never wrap.
REQ-027 SHALL assume requesters hold data stable while req and gnt are high and the word is not yet accepted; the block does not check this.

Reset
REQ-028 SHALL, while rst_n=0 (asynchronously, including mid-burst), force state=IDLE, gnt=0000, sel=00, ptr=11, beat count=0, out_valid=0, busy=0, out=16'h0000.
REQ-029 SHALL grant requester 0 first after reset when all requests are high (ptr=11).
REQ-030 SHALL begin arbitration at the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL test reset: rst_n=0 with req=1111 -> gnt=0000, out_valid=0, out=0000, busy=0.
REQ-032 SHALL test a single requester: req=0100, c=AAAA, out_ready=1 -> gnt=0100 one edge later; 4 words AAAA with out_valid=1; one IDLE cycle; then a new grant to 0100.
REQ-033 SHALL test round robin: req=1111, a=1234, b=9876, c=AAAA, d=5555, out_ready=1 -> grant order 0001, 0010, 0100, 1000, 0001, with 4 beats each of the matching word.
REQ-034 SHALL test backpressure: during a grant to b, out_ready=0 for 3 cycles -> out=9876, out_valid=1, sel=01 held; beat count frozen; burst completes after out_ready returns.
REQ-035 SHALL test an early drop: req[0] deasserts after 2 beats while req[3]=1 -> out_valid=0 that cycle; IDLE next; then gnt=1000.
REQ-036 SHALL test reset mid-burst: pulse rst_n low during SERVE -> outputs clear immediately without a clock; after release with req=1111, the first grant is 0001.
